// File: rtl/i2s_sample_packer.sv
// i2s_sample_packer
//   Pops right-aligned samples from the I2S receive FIFO and packs 1, 2 or 4
//   of them little-endian by lane into 32-bit words. The packed words go out on
//   a valid/ready stream. out_last marks the end of each block and also marks
//   flush words. A flush forces out a zero-padded partial word.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   enable; low discards the partial accumulator state
//   pack_mode[1:0]       00/11: 1x32b, 01: 2x16b, 10: 4x8b per word
//   blk_words[BLK_W-1:0] words per block (0 = no block marking)
//   flush                one-cycle request to emit a partial word
//   fifo_empty           FIFO empty flag
//   fifo_rdata[31:0]     FIFO head data (show-ahead)
//   fifo_rd              combinational pop strobe
//   out_data[31:0]       packed word
//   out_valid/out_ready  output handshake
//   out_last             last word of a block, or a flush word
//   busy                 partial lane data, a full accumulator or an output word pending
module i2s_sample_packer #(
  parameter int BLK_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       pack_mode,
  input  logic [BLK_W-1:0] blk_words,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [31:0]      fifo_rdata,
  output logic             fifo_rd,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [1:0] {
    MODE_32  = 2'b00,
    MODE_16  = 2'b01,
    MODE_8   = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(pack_mode);

  logic [31:0]      acc_q, acc_d;
  logic [1:0]       lane_q, lane_d;
  logic             acc_full_q, acc_full_d;
  logic             pad_last_q, pad_last_d;
  logic             flush_pend_q, flush_pend_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [BLK_W-1:0] wcnt_q, wcnt_d;

  logic             xfer;
  logic             hshake;
  logic             lane_last;
  logic             blk_hit;
  logic [31:0]      acc_wr;

  assign xfer    = acc_full_q & (~out_valid_q | out_ready);
  assign hshake  = out_valid_q & out_ready;
  assign fifo_rd = en & ~fifo_empty & (~acc_full_q | xfer) & ~flush_pend_q;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (lane_q != 2'd0) | acc_full_q | out_valid_q;

  // Lane geometry and the accumulator value after writing the popped sample.
  // A transfer in the same cycle clears the accumulator underneath the write.
  always_comb begin
    lane_last = 1'b1;
    acc_wr    = xfer ? '0 : acc_q;
    case (mode)
      MODE_16: begin
        lane_last = (lane_q == 2'd1);
        acc_wr[{lane_q[0], 4'b0000} +: 16] = fifo_rdata[15:0];
      end
      MODE_8: begin
        lane_last = (lane_q == 2'd3);
        acc_wr[{lane_q, 3'b000} +: 8] = fifo_rdata[7:0];
      end
      default: begin
        lane_last = 1'b1;
        acc_wr    = fifo_rdata;
      end
    endcase
  end

  always_comb begin
    acc_d        = acc_q;
    lane_d       = lane_q;
    acc_full_d   = acc_full_q;
    pad_last_d   = pad_last_q;
    flush_pend_d = flush_pend_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    wcnt_d       = wcnt_q;

    // Completed word: a block-final or flush word restarts the count.
    if (hshake) begin
      if (out_last_q) begin
        wcnt_d = '0;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end

    // The word being loaded takes the index the counter holds after this
    // cycle's completion, so back-to-back words are marked correctly.
    blk_hit = (blk_words != '0) && (wcnt_d == blk_words - 1'b1);

    if (xfer) begin
      out_data_d  = acc_q;
      out_valid_d = 1'b1;
      out_last_d  = pad_last_q | blk_hit;
      acc_full_d  = 1'b0;
      acc_d       = '0;
      pad_last_d  = 1'b0;
    end else if (hshake) begin
      out_valid_d = 1'b0;
    end

    if (fifo_rd) begin
      acc_d = acc_wr;
      if (lane_last) begin
        lane_d     = '0;
        acc_full_d = 1'b1;
      end else begin
        lane_d = lane_q + 2'd1;
      end
    end

    if (flush_pend_q && !acc_full_q) begin
      flush_pend_d = 1'b0;
      if (lane_q != 2'd0) begin
        acc_full_d = 1'b1;
        pad_last_d = 1'b1;
        lane_d     = '0;
      end
    end

    if (flush) begin
      flush_pend_d = 1'b1;
    end

    if (!en) begin
      acc_d        = '0;
      lane_d       = '0;
      acc_full_d   = 1'b0;
      pad_last_d   = 1'b0;
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      lane_q       <= '0;
      acc_full_q   <= 1'b0;
      pad_last_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      wcnt_q       <= '0;
    end else begin
      acc_q        <= acc_d;
      lane_q       <= lane_d;
      acc_full_q   <= acc_full_d;
      pad_last_q   <= pad_last_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      wcnt_q       <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_i2s_sample_packer.sv
module tb_i2s_sample_packer;
  localparam int BLK_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       pack_mode;
  logic [BLK_W-1:0] blk_words;
  logic             flush;
  logic             fifo_empty = 1'b1;
  logic [31:0]      fifo_rdata = 32'h0;
  logic             fifo_rd;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  i2s_sample_packer #(.BLK_W(BLK_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pack_mode  (pack_mode),
    .blk_words  (blk_words),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          rdy_rand = 1'b0;

  logic [31:0] fifo_q[$];
  logic [31:0] push_q[$];
  int unsigned rd_log[$];
  int unsigned vld_log[$];
  logic [32:0] exp_q[$];   // {last, data}
  logic [32:0] mon_e;

  // reference model state
  int unsigned m_k = 1;
  int unsigned m_w = 32;
  int unsigned m_n = 0;
  logic [31:0] m_word = '0;
  logic [7:0]  m_idx = '0;
  logic [7:0]  m_blk = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned at(input int unsigned q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  // FIFO model: pops on fifo_rd, then admits newly pushed samples.
  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_log.push_back(cyc);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (out_valid) vld_log.push_back(cyc);
    while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
    fifo_rdata <= (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    cyc <= cyc + 1;
  end

  // Monitor: every presented word must equal the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h last %0b expected none", out_data, out_last);
      end else begin
        mon_e = exp_q[0];
        chk("word_data", 64'(out_data), 64'(mon_e[31:0]));
        chk("word_last", 64'(out_last), 64'(mon_e[32]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic model_emit(input bit flushed);
    bit last;
    last = flushed || (m_blk != 8'd0 && m_idx == m_blk - 8'd1);
    exp_q.push_back({last, m_word});
    m_idx  = last ? 8'd0 : m_idx + 8'd1;
    m_word = '0;
    m_n    = 0;
  endtask

  task automatic push(input logic [31:0] s);
    logic [31:0] mask;
    mask   = (m_w == 32) ? 32'hFFFF_FFFF : ((32'd1 << m_w) - 32'd1);
    m_word = m_word | ((s & mask) << (m_w * m_n));
    m_n++;
    push_q.push_back(s);
    if (m_n == m_k) model_emit(1'b0);
  endtask

  task automatic configure(input logic [1:0] mode, input logic [7:0] blk);
    en = 1'b0;
    tick();
    pack_mode = mode;
    blk_words = blk;
    m_blk     = blk;
    case (mode)
      2'b01:   begin m_k = 2; m_w = 16; end
      2'b10:   begin m_k = 4; m_w = 8;  end
      default: begin m_k = 1; m_w = 32; end
    endcase
    en = 1'b1;
    tick();
  endtask

  task automatic drain_fifo();
    int unsigned n = 0;
    while ((fifo_q.size() != 0 || push_q.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL fifo_drain_timeout: got %0d left expected 0", fifo_q.size());
    end
    tick();
    tick();
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0 || fifo_q.size() != 0 || push_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got %0d words outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    if (m_n != 0) model_emit(1'b1);
    tick();
    flush = 1'b0;
  endtask

  task automatic model_discard();
    m_word = '0;
    m_n    = 0;
  endtask

  initial begin
    int unsigned f;
    int unsigned n;
    rst_n     = 1'b0;
    en        = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    pack_mode = 2'b00;
    blk_words = '0;
    repeat (3) tick();

    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_fifo_rd", 64'(fifo_rd), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();

    // mode 00 streaming
    out_ready = 1'b1;
    configure(2'b00, 8'd0);
    rd_log.delete();
    vld_log.delete();
    push(32'h1111_1111);
    push(32'h2222_2222);
    push(32'h3333_3333);
    drain_fifo();
    repeat (3) tick();
    chk("m00_pop_count", 64'(rd_log.size()), 64'd3);
    chk("m00_pop_consec", 64'(at(rd_log, 2) - at(rd_log, 0)), 64'd2);
    chk("m00_first_latency", 64'(at(vld_log, 0) - at(rd_log, 0)), 64'd2);
    chk("m00_word_count", 64'(vld_log.size()), 64'd3);
    chk("m00_word_consec", 64'(at(vld_log, 2) - at(vld_log, 0)), 64'd2);
    wait_idle();

    // mode 01 packing
    configure(2'b01, 8'd0);
    rd_log.delete();
    push(32'hFFFF_1234);
    push(32'h0000_ABCD);
    drain_fifo();
    repeat (3) tick();
    chk("m01_pop_count", 64'(rd_log.size()), 64'd2);
    wait_idle();

    // mode 10 with flush
    configure(2'b10, 8'd0);
    push(32'h0000_0001);
    push(32'h0000_0002);
    push(32'h0000_0003);
    drain_fifo();
    vld_log.delete();
    f = cyc;
    do_flush();
    repeat (5) tick();
    chk("flush_latency", 64'(at(vld_log, 0) - f), 64'd3);
    wait_idle();

    // block marking
    configure(2'b00, 8'd4);
    for (int i = 0; i < 10; i++) push($urandom);
    wait_idle();

    // backpressure
    out_ready = 1'b0;
    configure(2'b00, 8'd0);
    rd_log.delete();
    for (int i = 0; i < 5; i++) push($urandom);
    repeat (20) tick();
    chk("bp_pop_count", 64'(rd_log.size()), 64'd2);
    chk("bp_fifo_rd", 64'(fifo_rd), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_idle();

    // reset mid-word
    configure(2'b01, 8'd0);
    push(32'hCAFE_5A5A);
    drain_fifo();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_last", 64'(out_last), 64'd0);
    chk("midrst_fifo_rd", 64'(fifo_rd), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    model_discard();
    m_idx = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // disable mid-word with a word waiting in the output register
    configure(2'b01, 8'd0);
    out_ready = 1'b0;
    push(32'h0000_1111);
    push(32'h0000_2222);
    push(32'h0000_3333);
    drain_fifo();
    en = 1'b0;
    model_discard();
    tick();
    chk("dis_out_valid", 64'(out_valid), 64'd1);
    chk("dis_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    wait_idle();
    en = 1'b1;
    push(32'h0000_4444);
    push(32'h0000_5555);
    wait_idle();

    // randomized rounds
    rdy_rand = 1'b1;
    for (int r = 0; r < 40; r++) begin
      configure(2'($urandom_range(0, 3)), 8'($urandom_range(0, 5)));
      n = $urandom_range(1, 12);
      for (int i = 0; i < int'(n); i++) begin
        push($urandom);
        if ($urandom_range(0, 2) == 0) tick();
      end
      drain_fifo();
      if (m_n != 0) begin
        if ($urandom_range(0, 1) == 0) begin
          do_flush();
        end else begin
          en = 1'b0;
          model_discard();
          tick();
        end
      end else if ($urandom_range(0, 2) == 0) begin
        do_flush();
      end
      wait_idle();
    end
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
